// File: rtl/matrix_stream_if.sv
// Bundle of the matrix store's write, random-read, stream-control and
// stream-output signals; the master side drives requests, the slave is the store.
interface matrix_stream_if #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 16,
    parameter int COLS   = 16
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic              clr;
    logic              we;
    logic [RW-1:0]     wrow;
    logic [CW-1:0]     wcol;
    logic [DATA_W-1:0] wdata;
    logic [RW-1:0]     rrow;
    logic [CW-1:0]     rcol;
    logic [DATA_W-1:0] rdata;
    logic              start;
    logic              mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [RW-1:0]     out_row;
    logic [CW-1:0]     out_col;
    logic              out_last;
    logic              busy;
    logic              wr_drop;

    modport master (
        output clr, we, wrow, wcol, wdata, rrow, rcol, start, mode, out_ready,
        input  rdata, out_valid, out_data, out_row, out_col, out_last, busy, wr_drop
    );

    modport slave (
        input  clr, we, wrow, wcol, wdata, rrow, rcol, start, mode, out_ready,
        output rdata, out_valid, out_data, out_row, out_col, out_last, busy, wr_drop
    );
endinterface

// File: rtl/matrix_stream.sv
// ROWS x COLS element store with random-access write/read and a ready/valid
// streaming reader that walks the matrix in row-major or column-major order.
module matrix_stream #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 16,
    parameter int COLS   = 16
) (
    input  logic             clk,
    input  logic             rst,
    matrix_stream_if.slave   bus
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    // One extra bit so the bound itself is representable for range checks.
    localparam logic [RW:0]   ROWS_L   = ROWS[RW:0];
    localparam logic [CW:0]   COLS_L   = COLS[CW:0];
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t            state_reg;
    logic              mode_reg;
    logic [RW-1:0]     row_reg;
    logic [CW-1:0]     col_reg;
    logic              valid_reg;
    logic              busy_reg;
    logic              drop_reg;
    logic [DATA_W-1:0] mem [ROWS][COLS];

    logic wr_in_range;
    logic rd_in_range;
    logic wr_en;
    logic at_last;

    assign wr_in_range = ({1'b0, bus.wrow} < ROWS_L) && ({1'b0, bus.wcol} < COLS_L);
    assign rd_in_range = ({1'b0, bus.rrow} < ROWS_L) && ({1'b0, bus.rcol} < COLS_L);
    assign wr_en       = !bus.clr && bus.we && (state_reg == IDLE) && wr_in_range;
    assign at_last     = (row_reg == LAST_ROW) && (col_reg == LAST_COL);

    // Storage is flops rather than block RAM: it must clear in one cycle and on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    mem[r][c] <= '0;
        end else if (bus.clr) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    mem[r][c] <= '0;
        end else if (wr_en) begin
            mem[bus.wrow][bus.wcol] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            mode_reg  <= 1'b0;
            row_reg   <= '0;
            col_reg   <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            drop_reg  <= 1'b0;
        end else if (bus.clr) begin
            state_reg <= IDLE;
            row_reg   <= '0;
            col_reg   <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            drop_reg  <= 1'b0;
        end else begin
            drop_reg <= bus.we && (state_reg == STREAM);
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg <= STREAM;
                        mode_reg  <= bus.mode;
                        row_reg   <= '0;
                        col_reg   <= '0;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (bus.out_ready) begin
                        if (at_last) begin
                            state_reg <= IDLE;
                            row_reg   <= '0;
                            col_reg   <= '0;
                            valid_reg <= 1'b0;
                            busy_reg  <= 1'b0;
                        end else if (!mode_reg) begin
                            if (col_reg == LAST_COL) begin
                                col_reg <= '0;
                                row_reg <= row_reg + RW'(1);
                            end else begin
                                col_reg <= col_reg + CW'(1);
                            end
                        end else begin
                            if (row_reg == LAST_ROW) begin
                                row_reg <= '0;
                                col_reg <= col_reg + CW'(1);
                            end else begin
                                row_reg <= row_reg + RW'(1);
                            end
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.rdata     = rd_in_range ? mem[bus.rrow][bus.rcol] : '0;
    assign bus.out_valid = valid_reg;
    assign bus.out_data  = mem[row_reg][col_reg];
    assign bus.out_row   = row_reg;
    assign bus.out_col   = col_reg;
    assign bus.out_last  = valid_reg && at_last;
    assign bus.busy      = busy_reg;
    assign bus.wr_drop   = drop_reg;
endmodule

// File: tb/tb_matrix_stream.sv
// Bench for matrix_stream (3x4, 8-bit): a queue-based model of the matrix and its
// stream order is checked every cycle, plus literal expectations on captured streams.
module tb_matrix_stream;
    localparam int DATA_W = 8;
    localparam int ROWS   = 3;
    localparam int COLS   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matrix_stream_if #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS)) bus ();

    matrix_stream #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int r;
        int c;
        int d;
    } elem_t;

    int    checks   = 0;
    int    failures = 0;
    int    m_mem [ROWS][COLS];
    elem_t m_q [$];
    bit    m_busy = 1'b0;
    bit    m_drop = 1'b0;
    int    cap [$];
    int    lastcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m_mem[r][c] = 0;
        m_q.delete();
        m_busy = 1'b0;
        m_drop = 1'b0;
    endtask

    // Model: storage array plus a queue holding the rest of the current stream.
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.clr) begin
                model_clear();
            end else begin
                m_drop = bus.we && m_busy;
                if (m_busy) begin
                    if (bus.out_ready) begin
                        void'(m_q.pop_front());
                        if (m_q.size() == 0) m_busy = 1'b0;
                    end
                end else begin
                    if (bus.we && bus.wrow < ROWS && bus.wcol < COLS)
                        m_mem[bus.wrow][bus.wcol] = int'(bus.wdata);
                    if (bus.start) begin
                        if (!bus.mode) begin
                            for (int r = 0; r < ROWS; r++)
                                for (int c = 0; c < COLS; c++)
                                    m_q.push_back('{r: r, c: c, d: m_mem[r][c]});
                        end else begin
                            for (int c = 0; c < COLS; c++)
                                for (int r = 0; r < ROWS; r++)
                                    m_q.push_back('{r: r, c: c, d: m_mem[r][c]});
                        end
                        m_busy = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        int exp_rd;
        exp_rd = (bus.rrow < ROWS && bus.rcol < COLS) ? m_mem[bus.rrow][bus.rcol] : 0;
        chk("out_valid", bus.out_valid, m_busy);
        chk("busy", bus.busy, m_busy);
        chk("wr_drop", bus.wr_drop, m_drop);
        chk("rdata", bus.rdata, exp_rd);
        if (m_busy && m_q.size() > 0) begin
            chk("out_data", bus.out_data, m_q[0].d);
            chk("out_row", bus.out_row, m_q[0].r);
            chk("out_col", bus.out_col, m_q[0].c);
            chk("out_last", bus.out_last, m_q.size() == 1);
        end else begin
            chk("out_last_idle", bus.out_last, 0);
        end
        if (bus.out_valid && bus.out_ready) begin
            cap.push_back(int'(bus.out_data));
            if (bus.out_last) lastcnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int r, input int c, input int v);
        bus.we    = 1'b1;
        bus.wrow  = r[1:0];
        bus.wcol  = c[1:0];
        bus.wdata = v[7:0];
        bus.rrow  = r[1:0];
        bus.rcol  = c[1:0];
        step();
        bus.we = 1'b0;
    endtask

    // Start a stream and drive out_ready from a 4-cycle pattern until busy drops.
    task automatic run_stream(input logic md, input logic [3:0] pat, input int exp_cycles);
        int n;
        cap.delete();
        lastcnt   = 0;
        bus.start = 1'b1;
        bus.mode  = md;
        step();
        bus.start = 1'b0;
        bus.we    = 1'b0;
        n = 0;
        while (bus.busy && n < 200) begin
            bus.out_ready = pat[n % 4];
            bus.rrow      = 2'(n % 4);
            bus.rcol      = 2'((n / 4) % 4);
            step();
            n++;
        end
        chk("stream_done", bus.busy, 0);
        if (exp_cycles >= 0) chk("stream_cycles", n, exp_cycles);
        bus.out_ready = 1'b1;
    endtask

    int cm_exp [12] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.clr = 0; bus.we = 0; bus.wrow = 0; bus.wcol = 0; bus.wdata = 0;
        bus.rrow = 0; bus.rcol = 0; bus.start = 0; bus.mode = 0; bus.out_ready = 1;
        model_clear();
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_drop", bus.wr_drop, 0);
        chk("rst_last", bus.out_last, 0);
        chk("rst_row", bus.out_row, 0);
        chk("rst_col", bus.out_col, 0);
        chk("rst_rdata", bus.rdata, 0);
        step();
        step();
        rst = 1'b0;

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                write(r, c, r * 4 + c);
        write(3, 0, 8'h33);
        chk("oor_rdata", bus.rdata, 0);
        bus.rrow = 2; bus.rcol = 3;
        #1 chk("cell_2_3", bus.rdata, 11);

        run_stream(1'b0, 4'hF, 12);
        chk("rm_len", cap.size(), 12);
        chk("rm_lastcnt", lastcnt, 1);
        for (int i = 0; i < cap.size(); i++) chk("rm_seq", cap[i], i);

        run_stream(1'b1, 4'hF, 12);
        chk("cm_len", cap.size(), 12);
        for (int i = 0; i < cap.size() && i < 12; i++) chk("cm_seq", cap[i], cm_exp[i]);

        run_stream(1'b0, 4'b1001, -1);
        chk("stall_len", cap.size(), 12);
        chk("stall_lastcnt", lastcnt, 1);
        for (int i = 0; i < cap.size(); i++) chk("stall_seq", cap[i], i);

        // Dropped write and ignored start during a stalled stream, then clear.
        bus.out_ready = 1'b0;
        bus.start = 1'b1; bus.mode = 1'b0;
        step();
        bus.start = 1'b0;
        step();
        bus.we = 1; bus.wrow = 1; bus.wcol = 1; bus.wdata = 8'hAA;
        bus.start = 1'b1; bus.mode = 1'b1;
        bus.rrow = 1; bus.rcol = 1;
        step();
        bus.we = 0; bus.start = 0;
        chk("drop_pulse", bus.wr_drop, 1);
        chk("drop_keep", bus.rdata, 5);
        bus.out_ready = 1'b1;
        step();
        chk("drop_once", bus.wr_drop, 0);
        step();
        step();
        chk("post_start_col", bus.out_col, 3);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        chk("clr_valid", bus.out_valid, 0);
        chk("clr_busy", bus.busy, 0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < COLS; c++) begin
                bus.rrow = r[1:0]; bus.rcol = c[1:0];
                #1 chk("clr_rdata", bus.rdata, 0);
            end

        // Asynchronous reset between edges in the middle of a stream.
        write(0, 0, 7);
        write(2, 3, 9);
        bus.start = 1'b1; bus.mode = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        bus.rrow = 2; bus.rcol = 3;
        #3;
        rst = 1'b1;
        model_clear();
        #1;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_rdata", bus.rdata, 0);
        step();
        rst = 1'b0;
        step();
        run_stream(1'b0, 4'hF, 12);
        chk("zero_len", cap.size(), 12);
        chk("zero_lastcnt", lastcnt, 1);
        for (int i = 0; i < cap.size(); i++) chk("zero_seq", cap[i], 0);

        // Write and start in the same idle cycle: stream sees the new value.
        bus.we = 1; bus.wrow = 0; bus.wcol = 0; bus.wdata = 8'h55;
        run_stream(1'b0, 4'hF, 12);
        chk("sw_first", cap.size() > 0 ? cap[0] : -1, 8'h55);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
